// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O controller on the cpu IO_BUS: LEDs, scanned 8-digit hex display, debounced buttons.
// Optional build macro IO_CYCLE_CNT_EN adds a free-running 32-bit cycle counter readable at 0x14.

module io_btn_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // cnt holds how many consecutive synced samples have disagreed with the accepted level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      level_d <= level;
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= sync_q[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pulse = level & ~level_d;
endmodule

module io_bus_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic        btn_in,
  input  logic        btn_ok,
  output logic [15:0] led,
  output logic [2:0]  an,
  output logic [3:0]  seg_d
);
  localparam logic [5:0] A_LED   = 6'h00;
  localparam logic [5:0] A_READY = 6'h01;
  localparam logic [5:0] A_SEG   = 6'h02;
  localparam logic [5:0] A_INV   = 6'h03;
  localparam logic [5:0] A_IND   = 6'h04;
  localparam logic [5:0] A_CYC   = 6'h05;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [5:0]        word;
  logic [31:0]       seg_reg;
  logic              out_valid;
  logic              in_valid;
  logic [15:0]       in_data;
  logic [SCAN_W-1:0] scan_cnt;
  logic              in_pulse;
  logic              ok_pulse;
  logic              ack;
  logic              in_valid_acked;
  logic              unused_addr;

  assign word        = io_addr[7:2];
  assign unused_addr = &{1'b0, io_addr[1:0]};

  io_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_in (
    .clk(clk), .rst(rst), .raw(btn_in), .pulse(in_pulse)
  );
  io_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ok (
    .clk(clk), .rst(rst), .raw(btn_ok), .pulse(ok_pulse)
  );

  // An ack in the same cycle as a press is applied first, so the press lands on a free slot
  assign ack            = io_we && (word == A_INV);
  assign in_valid_acked = in_valid && !ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led       <= 16'h0000;
      seg_reg   <= 32'h0;
      out_valid <= 1'b0;
      in_valid  <= 1'b0;
      in_data   <= 16'h0000;
    end else begin
      if (io_we && (word == A_LED)) led <= io_dout[15:0];

      if (io_we && (word == A_SEG)) begin
        seg_reg   <= io_dout;
        out_valid <= 1'b1;
      end else if (ok_pulse) begin
        out_valid <= 1'b0;
      end

      if (in_pulse && !in_valid_acked) begin
        in_data  <= sw;
        in_valid <= 1'b1;
      end else begin
        in_valid <= in_valid_acked;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      an       <= 3'd0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      an       <= an + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign seg_d = seg_reg[{an, 2'b00} +: 4];

`ifdef IO_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_cnt <= 32'h0;
    else     cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

  always_comb begin
    io_din = 32'h0;
    case (word)
      A_LED:   io_din = {16'h0, led};
      A_READY: io_din = {31'h0, ~out_valid};
      A_SEG:   io_din = seg_reg;
      A_INV:   io_din = {31'h0, in_valid};
      A_IND:   io_din = {16'h0, in_data};
`ifdef IO_CYCLE_CNT_EN
      A_CYC:   io_din = cycle_cnt;
`else
      A_CYC:   io_din = 32'h0;
`endif
      default: io_din = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_io_bus_ctrl.sv
// Scoreboard bench for io_bus_ctrl: directed stimulus pushes expectations, a negedge monitor pops and compares.
// Expectations assume DEBOUNCE_CYCLES=4 and SCAN_DIV=4.

module tb_io_bus_ctrl;
  localparam int DEB  = 4;
  localparam int SDIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  io_addr = 8'h00;
  logic [31:0] io_dout = 32'hFFFF_FFFF;
  logic        io_we = 1'b1;
  logic [31:0] io_din;
  logic [15:0] sw = 16'h0000;
  logic        btn_in = 1'b1;
  logic        btn_ok = 1'b0;
  logic [15:0] led;
  logic [2:0]  an;
  logic [3:0]  seg_d;

  int errors = 0;
  int checks = 0;

  // kind 0: io_din, kind 1: led, kind 2: {an, seg_d}
  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  logic        rd_pend = 1'b0;

  io_bus_ctrl #(.DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SDIV)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
    .io_din(io_din), .sw(sw), .btn_in(btn_in), .btn_ok(btn_ok),
    .led(led), .an(an), .seg_d(seg_d)
  );

  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    if (rd_pend) begin
      logic [31:0] exp_v;
      logic [31:0] act_v;
      int          k;
      string       n;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: output presented with empty expected queue");
      end else begin
        exp_v = exp_q.pop_front();
        k     = kind_q.pop_front();
        n     = name_q.pop_front();
        case (k)
          1:       act_v = {16'h0, led};
          2:       act_v = {25'h0, an, seg_d};
          default: act_v = io_din;
        endcase
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", n, act_v, exp_v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int kind, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    kind_q.push_back(kind);
    name_q.push_back(n);
    rd_pend = 1'b1;
    tick();
    rd_pend = 1'b0;
  endtask

  task automatic read_chk(input logic [7:0] a, input logic [31:0] e, input string n);
    io_addr = a;
    expect_out(0, e, n);
  endtask

  task automatic write_bus(input logic [7:0] a, input logic [31:0] d);
    io_addr = a;
    io_dout = d;
    io_we   = 1'b1;
    tick();
    io_we   = 1'b0;
  endtask

  task automatic press_in(input int hold);
    btn_in = 1'b1;
    repeat (hold) tick();
    btn_in = 1'b0;
    repeat (12) tick();
  endtask

  task automatic press_ok(input int hold);
    btn_ok = 1'b1;
    repeat (hold) tick();
    btn_ok = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    logic [2:0]  prev_an;
    logic        found;
    logic [31:0] c0;

    // Reset held with btn_in pressed and io_we asserted
    repeat (2) tick();
    read_chk(8'h00, 32'h0, "rst_led_rd");
    read_chk(8'h04, 32'h1, "rst_ready_rd");
    read_chk(8'h08, 32'h0, "rst_seg_rd");
    read_chk(8'h0C, 32'h0, "rst_inv_rd");
    read_chk(8'h10, 32'h0, "rst_ind_rd");
    read_chk(8'h14, 32'h0, "rst_cyc_rd");
    expect_out(1, 32'h0, "rst_led_port");
    expect_out(2, 32'h0, "rst_an_seg");
    rst   = 1'b0;
    io_we = 1'b0;
    read_chk(8'h0C, 32'h0, "post_rst_inv_0");
    read_chk(8'h0C, 32'h0, "post_rst_inv_1");
    btn_in = 1'b0;
    repeat (12) tick();
    read_chk(8'h0C, 32'h0, "post_rst_inv_settled");

    // LEDs
    write_bus(8'h00, 32'h0001_A5C3);
    expect_out(1, 32'h0000_A5C3, "led_port");
    read_chk(8'h00, 32'h0000_A5C3, "led_rd");
    write_bus(8'h20, 32'h0000_1234);
    write_bus(8'h10, 32'h0000_5555);
    read_chk(8'h00, 32'h0000_A5C3, "led_after_unmapped_wr");
    read_chk(8'h10, 32'h0, "ind_write_ignored");

    // Display output and scan
    write_bus(8'h08, 32'h1234_5678);
    read_chk(8'h04, 32'h0, "ready_after_seg_wr");
    read_chk(8'h08, 32'h1234_5678, "seg_rd");
    found   = 1'b0;
    prev_an = an;
    for (int t = 0; t < 100 && !found; t++) begin
      tick();
      if (prev_an == 3'd7 && an == 3'd0) found = 1'b1;
      prev_an = an;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL scan_sync: no an 7->0 wrap within 100 cycles, an=%0d", an);
    end else begin
      for (int i = 0; i < 8; i++) begin
        expect_out(2, (32'(i) << 4) | 32'(8 - i), $sformatf("scan_digit_%0d", i));
        repeat (SDIV - 1) tick();
      end
    end
    press_ok(10);
    read_chk(8'h04, 32'h1, "ready_after_ok");

    // Input capture
    sw = 16'hBEEF;
    press_in(10);
    read_chk(8'h0C, 32'h1, "inv_after_press");
    read_chk(8'h10, 32'h0000_BEEF, "ind_after_press");
    sw = 16'h1111;
    press_in(10);
    read_chk(8'h10, 32'h0000_BEEF, "ind_held_while_valid");
    read_chk(8'h0C, 32'h1, "inv_still_set");
    write_bus(8'h0C, 32'h0);
    read_chk(8'h0C, 32'h0, "inv_after_ack");

    // Short glitch is rejected
    sw = 16'h4444;
    press_in(DEB - 1);
    read_chk(8'h0C, 32'h0, "glitch_no_capture");
    read_chk(8'h10, 32'h0000_BEEF, "glitch_ind_unchanged");

    // Ack coincident with a press pulse: press pulse is consumed at the 7th edge
    sw = 16'h2222;
    press_in(10);
    read_chk(8'h0C, 32'h1, "inv_before_coincident");
    sw     = 16'h3333;
    btn_in = 1'b1;
    repeat (6) tick();
    write_bus(8'h0C, 32'h0);
    read_chk(8'h0C, 32'h1, "coincident_inv");
    read_chk(8'h10, 32'h0000_3333, "coincident_ind");
    btn_in = 1'b0;
    repeat (12) tick();

    // Cycle counter and unmapped reads
`ifdef IO_CYCLE_CNT_EN
    io_addr = 8'h14;
    c0 = io_din;
    repeat (5) tick();
    expect_out(0, c0 + 32'd5, "cyc_delta_5");
`else
    c0 = 32'h0;
    read_chk(8'h14, c0, "cyc_disabled");
`endif
    read_chk(8'h20, 32'h0, "unmapped_20");
    read_chk(8'hFC, 32'h0, "unmapped_fc");

    repeat (2) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
